// File: rtl/sdio_dat_tx_controller.sv
// SDIO DAT read-transfer sequencer: streams bytes from an on-chip buffer
// into the 4-bit DAT response streamer using a one-byte prefetch register.
module sdio_dat_tx_controller #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_data4_strobe,
  input  logic [8:0]            data4_count,
  input  logic [ADDR_WIDTH-1:0] buf_base,
  input  logic                  abort,
  input  logic                  send_data_in_progress,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [7:0]            buf_rd_data,
  output logic                  start_write,
  input  logic                  data_req,
  output logic                  data_strobe,
  output logic [7:0]            data,
  output logic                  data_empty,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [9:0]            bytes_left
);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, DRAIN, WAIT_DONE} state_t;

  state_t                state_reg, state_next;
  logic [9:0]            bytes_left_reg, bytes_left_next;
  logic                  rd_en_reg, rd_en_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic                  rd_pending_reg, rd_pending_next;   // buffer data is on buf_rd_data this cycle
  logic                  pf_valid_reg, pf_valid_next;
  logic [7:0]            pf_data_reg, pf_data_next;
  logic                  req_pending_reg, req_pending_next; // request waiting for a refill to land
  logic [7:0]            data_reg, data_next;
  logic                  strobe_reg, strobe_next;
  logic                  empty_reg, empty_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  error_reg, error_next;
  logic                  sw_reg, sw_next;

  logic have_byte;
  logic want_byte;

  // A byte can be handed over either from the prefetch register or straight
  // from the buffer bus in the cycle a refill lands.
  assign have_byte = pf_valid_reg || rd_pending_reg;
  assign want_byte = req_pending_reg || data_req;

  // Next-state and next-output computation; abort overrides everything last.
  always_comb begin
    state_next       = state_reg;
    bytes_left_next  = bytes_left_reg;
    rd_en_next       = 1'b0;
    rd_addr_next     = rd_addr_reg;
    rd_pending_next  = rd_en_reg;
    pf_valid_next    = pf_valid_reg;
    pf_data_next     = pf_data_reg;
    req_pending_next = req_pending_reg;
    data_next        = data_reg;
    strobe_next      = 1'b0;
    empty_next       = empty_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    error_next       = 1'b0;
    sw_next          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (write_data4_strobe) begin
          bytes_left_next  = (data4_count == 9'd0) ? 10'd512 : {1'b0, data4_count};
          rd_addr_next     = buf_base;
          rd_en_next       = 1'b1;
          busy_next        = 1'b1;
          empty_next       = 1'b0;
          pf_valid_next    = 1'b0;
          req_pending_next = 1'b0;
          state_next       = FETCH;
        end
      end
      FETCH: begin
        sw_next    = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        if (data_req && req_pending_reg) begin
          error_next = 1'b1;
        end
        if (want_byte && have_byte) begin
          data_next        = pf_valid_reg ? pf_data_reg : buf_rd_data;
          strobe_next      = 1'b1;
          bytes_left_next  = bytes_left_reg - 10'd1;
          pf_valid_next    = 1'b0;
          req_pending_next = 1'b0;
          if (bytes_left_reg != 10'd1) begin
            rd_en_next   = 1'b1;
            rd_addr_next = rd_addr_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            state_next = DRAIN;
          end
        end else begin
          if (data_req) begin
            req_pending_next = 1'b1;
          end
          if (rd_pending_reg) begin
            pf_data_next  = buf_rd_data;
            pf_valid_next = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (data_req) begin
          empty_next = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!send_data_in_progress) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_reg != IDLE && write_data4_strobe) begin
      error_next = 1'b1;
    end

    if (state_reg != IDLE && abort) begin
      state_next       = IDLE;
      bytes_left_next  = 10'd0;
      rd_en_next       = 1'b0;
      rd_pending_next  = 1'b0;
      pf_valid_next    = 1'b0;
      req_pending_next = 1'b0;
      strobe_next      = 1'b0;
      empty_next       = 1'b1;
      busy_next        = 1'b0;
      done_next        = 1'b0;
      error_next       = 1'b0;
      sw_next          = 1'b0;
      data_next        = data_reg;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      bytes_left_reg  <= 10'd0;
      rd_en_reg       <= 1'b0;
      rd_addr_reg     <= '0;
      rd_pending_reg  <= 1'b0;
      pf_valid_reg    <= 1'b0;
      pf_data_reg     <= 8'd0;
      req_pending_reg <= 1'b0;
      data_reg        <= 8'd0;
      strobe_reg      <= 1'b0;
      empty_reg       <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      sw_reg          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bytes_left_reg  <= bytes_left_next;
      rd_en_reg       <= rd_en_next;
      rd_addr_reg     <= rd_addr_next;
      rd_pending_reg  <= rd_pending_next;
      pf_valid_reg    <= pf_valid_next;
      pf_data_reg     <= pf_data_next;
      req_pending_reg <= req_pending_next;
      data_reg        <= data_next;
      strobe_reg      <= strobe_next;
      empty_reg       <= empty_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
      sw_reg          <= sw_next;
    end
  end

  assign buf_rd_en   = rd_en_reg;
  assign buf_rd_addr = rd_addr_reg;
  assign start_write = sw_reg;
  assign data_strobe = strobe_reg;
  assign data        = data_reg;
  assign data_empty  = empty_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign bytes_left  = bytes_left_reg;

endmodule

// File: tb/tb_sdio_dat_tx_controller.sv
// Directed bench for sdio_dat_tx_controller with a transfer-level reference
// model and a per-cycle output comparison.
module tb_sdio_dat_tx_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       write_data4_strobe;
  logic [8:0] data4_count;
  logic [8:0] buf_base;
  logic       abort;
  logic       send_data_in_progress;
  logic       buf_rd_en;
  logic [8:0] buf_rd_addr;
  logic [7:0] buf_rd_data = 8'd0;
  logic       start_write;
  logic       data_req;
  logic       data_strobe;
  logic [7:0] data;
  logic       data_empty;
  logic       busy;
  logic       done;
  logic       error;
  logic [9:0] bytes_left;

  sdio_dat_tx_controller #(.ADDR_WIDTH(9)) dut (
    .clock(clock), .reset_n(reset_n),
    .write_data4_strobe(write_data4_strobe), .data4_count(data4_count),
    .buf_base(buf_base), .abort(abort),
    .send_data_in_progress(send_data_in_progress),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .start_write(start_write), .data_req(data_req), .data_strobe(data_strobe),
    .data(data), .data_empty(data_empty), .busy(busy), .done(done),
    .error(error), .bytes_left(bytes_left)
  );

  always #5 clock = ~clock;

  // Byte buffer with one-cycle registered read.
  logic [7:0] mem [0:511];
  always @(posedge clock) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: values expected in the cycle after the latest edge,
  // plus the cycle numbers at which one-shot events are due.
  bit         m_busy, m_empty, m_emptied;
  int         m_bl, m_n, m_acc;
  logic [7:0] m_data;
  logic [8:0] m_rd_addr;
  int         m_strobe_cyc, m_sw_cyc, m_done_cyc, m_err_cyc, m_rd_cyc;
  int         m_avail, m_stream_from, m_wait_from;
  logic [7:0] m_q[$];

  // Observation log.
  logic [7:0] obs_q[$];
  int         strobe_cyc_q[$];
  int         rd_cnt = 0, done_cnt = 0, err_cnt = 0, sw_seen = -9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_empty = 1; m_emptied = 0; m_bl = 0; m_n = 0; m_acc = 0;
    m_data = 8'd0; m_rd_addr = 9'd0;
    m_strobe_cyc = -9; m_sw_cyc = -9; m_done_cyc = -9; m_err_cyc = -9; m_rd_cyc = -9;
    m_avail = 0; m_stream_from = 0; m_wait_from = 0;
    m_q.delete();
  endtask

  // Transfer rules: a byte is handed over the cycle after the request once
  // buffer data is available; data becomes available two cycles after the
  // accepted strobe and one cycle after each refill-issuing strobe.
  task automatic model_step();
    int c;
    int s;
    c = cyc;
    if (!reset_n) begin
      model_reset();
      cyc++;
      return;
    end
    if (m_busy) begin
      if (abort) begin
        m_busy = 0; m_empty = 1; m_bl = 0;
        if (m_strobe_cyc > c) m_strobe_cyc = -9;
        if (m_sw_cyc > c)     m_sw_cyc = -9;
        if (m_rd_cyc > c)     m_rd_cyc = -9;
        m_q.delete();
      end else begin
        if (write_data4_strobe) m_err_cyc = c + 1;
        if (data_req && c >= m_stream_from) begin
          if (m_strobe_cyc > c) begin
            m_err_cyc = c + 1;
          end else if (m_acc < m_n) begin
            s = ((c > m_avail) ? c : m_avail) + 1;
            m_strobe_cyc = s;
            m_avail = s + 1;
            m_acc++;
          end else if (!m_emptied) begin
            m_emptied = 1; m_empty = 1; m_wait_from = c + 1;
          end
        end
        if (m_emptied && c >= m_wait_from && !send_data_in_progress) begin
          m_done_cyc = c + 1; m_busy = 0;
        end
      end
    end else if (write_data4_strobe) begin
      m_n = (data4_count == 9'd0) ? 512 : int'(data4_count);
      m_bl = m_n; m_busy = 1; m_empty = 0; m_emptied = 0; m_acc = 0;
      m_sw_cyc = c + 2; m_avail = c + 2; m_stream_from = c + 2;
      m_rd_cyc = c + 1; m_rd_addr = buf_base;
      m_q.delete();
      for (int i = 0; i < m_n; i++) m_q.push_back(mem[9'(int'(buf_base) + i)]);
    end
    if (m_strobe_cyc == c + 1) begin
      m_data = m_q.pop_front();
      m_bl--;
      if (m_bl > 0) begin
        m_rd_cyc = c + 1;
        m_rd_addr = m_rd_addr + 9'd1;
      end
    end
    cyc++;
  endtask

  task automatic check_cycle();
    chk("busy", busy, m_busy);
    chk("data_empty", data_empty, m_empty);
    chk("bytes_left", bytes_left, m_bl);
    chk("data_strobe", data_strobe, cyc == m_strobe_cyc);
    chk("data", data, m_data);
    chk("start_write", start_write, cyc == m_sw_cyc);
    chk("done", done, cyc == m_done_cyc);
    chk("error", error, cyc == m_err_cyc);
    chk("buf_rd_en", buf_rd_en, cyc == m_rd_cyc);
    if (cyc == m_rd_cyc) chk("buf_rd_addr", buf_rd_addr, m_rd_addr);
    if (data_strobe) begin obs_q.push_back(data); strobe_cyc_q.push_back(cyc); end
    if (buf_rd_en)   rd_cnt++;
    if (done)        done_cnt++;
    if (error)       err_cnt++;
    if (start_write) sw_seen = cyc;
  endtask

  // One clock: compare on the falling edge, step the model on the rising
  // edge, then leave the driver 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      check_cycle();
      @(posedge clock);
      model_step();
      #1;
    end
  endtask

  task automatic pulse_strobe(input logic [8:0] cnt, input logic [8:0] base);
    write_data4_strobe = 1'b1; data4_count = cnt; buf_base = base;
    tick(1);
    write_data4_strobe = 1'b0;
  endtask

  task automatic req();
    data_req = 1'b1;
    tick(1);
    data_req = 1'b0;
  endtask

  int o0, r0, d0, e0, rd0, sc0, st0, rq0, xfer;

  task automatic snap();
    o0 = obs_q.size(); d0 = done_cnt; e0 = err_cnt; rd0 = rd_cnt;
    sc0 = strobe_cyc_q.size();
  endtask

  task automatic report(input int base, input int cnt);
    xfer++;
    $display("xfer %0d: base=%03h count=%0d bytes=%0d reads=%0d done=%0d errors=%0d",
             xfer, base, cnt, obs_q.size() - o0, rd_cnt - rd0, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    xfer = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'hA5;
    reset_n = 1'b0; write_data4_strobe = 1'b0; data4_count = 9'd0; buf_base = 9'd0;
    abort = 1'b0; send_data_in_progress = 1'b1; data_req = 1'b0;
    model_reset();
    tick(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_empty", data_empty, 1'b1);
    chk("rst_bytes_left", bytes_left, 10'd0);
    reset_n = 1'b1;
    tick(2);

    // 4-byte transfer, slow requests.
    snap();
    st0 = cyc;
    pulse_strobe(9'd4, 9'd0);
    tick(19);
    rq0 = cyc;
    for (int k = 0; k < 5; k++) begin req(); tick(19); end
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t1_sw_latency", sw_seen - st0, 2);
    chk("t1_req_latency", strobe_cyc_q[sc0] - rq0, 1);
    chk("t1_byte0", obs_q[o0],   8'hA5);
    chk("t1_byte1", obs_q[o0+1], 8'hA4);
    chk("t1_byte2", obs_q[o0+2], 8'hA7);
    chk("t1_byte3", obs_q[o0+3], 8'hA6);
    chk("t1_reads", rd_cnt - rd0, 4);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_empty", data_empty, 1'b1);
    report(0, 4);

    // 512-byte transfer wrapping the buffer address.
    snap();
    pulse_strobe(9'd0, 9'h1FE);
    chk("t2_bl512", bytes_left, 10'd512);
    tick(3);
    for (int k = 0; k < 513; k++) begin req(); tick(2); end
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t2_count", obs_q.size() - o0, 512);
    chk("t2_first", obs_q[o0], 8'h5B);
    chk("t2_wrap", obs_q[o0+2], 8'hA5);
    chk("t2_last", obs_q[o0+511], 8'h58);
    chk("t2_reads", rd_cnt - rd0, 512);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_bl0", bytes_left, 10'd0);
    report(9'h1FE, 512);

    // Back-to-back requests and a request while one is pending.
    snap();
    pulse_strobe(9'd4, 9'h010);
    tick(5);
    r0 = cyc;
    req(); req(); req();
    tick(8);
    for (int k = 0; k < 3; k++) begin req(); tick(9); end
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t3_b2b_latency", strobe_cyc_q[sc0+1] - (r0 + 1), 2);
    chk("t3_errors", err_cnt - e0, 1);
    chk("t3_byte0", obs_q[o0],   8'hB5);
    chk("t3_byte1", obs_q[o0+1], 8'hB4);
    chk("t3_byte2", obs_q[o0+2], 8'hB7);
    chk("t3_byte3", obs_q[o0+3], 8'hB6);
    chk("t3_done", done_cnt - d0, 1);
    report(9'h010, 4);

    // Strobe while streaming is rejected.
    snap();
    pulse_strobe(9'd3, 9'h020);
    tick(5);
    req(); tick(5);
    pulse_strobe(9'd7, 9'h040);
    tick(5);
    for (int k = 0; k < 3; k++) begin req(); tick(5); end
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t4_errors", err_cnt - e0, 1);
    chk("t4_count", obs_q.size() - o0, 3);
    chk("t4_byte2", obs_q[o0+2], 8'h87);
    chk("t4_reads", rd_cnt - rd0, 3);
    chk("t4_done", done_cnt - d0, 1);
    report(9'h020, 3);

    // Abort after two bytes, then a fresh one-byte transfer.
    snap();
    pulse_strobe(9'd8, 9'h030);
    tick(5);
    req(); tick(5); req(); tick(5);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("t5_abort_busy", busy, 1'b0);
    chk("t5_abort_empty", data_empty, 1'b1);
    chk("t5_abort_bl", bytes_left, 10'd0);
    tick(5);
    chk("t5_no_done", done_cnt - d0, 0);
    pulse_strobe(9'd1, 9'h100);
    tick(5);
    req(); tick(5); req(); tick(5);
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t5_byte1", obs_q[o0+1], 8'h94);
    chk("t5_new_byte", obs_q[o0+2], 8'hA5);
    chk("t5_count", obs_q.size() - o0, 3);
    chk("t5_reads", rd_cnt - rd0, 4);
    chk("t5_done", done_cnt - d0, 1);
    report(9'h030, 8);

    // Asynchronous reset in the middle of a transfer.
    snap();
    pulse_strobe(9'd5, 9'h050);
    tick(5);
    req(); tick(5); req(); tick(2);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_empty", data_empty, 1'b1);
    chk("t6_bl", bytes_left, 10'd0);
    chk("t6_data", data, 8'd0);
    chk("t6_rd_addr", buf_rd_addr, 9'd0);
    chk("t6_outs", {buf_rd_en, start_write, data_strobe, done, error}, 5'd0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk("t6_idle_busy", busy, 1'b0);
    report(9'h050, 5);

    // Two-byte transfer across the top of the buffer after reset.
    snap();
    pulse_strobe(9'd2, 9'h1FF);
    tick(5);
    for (int k = 0; k < 3; k++) begin req(); tick(3); end
    send_data_in_progress = 1'b0; tick(3); send_data_in_progress = 1'b1;
    chk("t7_byte0", obs_q[o0],   8'h5A);
    chk("t7_byte1", obs_q[o0+1], 8'hA5);
    chk("t7_done", done_cnt - d0, 1);
    report(9'h1FF, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
